// File: rtl/sccb_req_arbiter_if.sv
// Bundle of requester handshake, status outputs and transceiver command/status
// signals shared between the SCCB request arbiter and its environment.
interface sccb_req_arbiter_if;
  logic [1:0]  req;
  logic [15:0] req_sub;
  logic [15:0] req_wdata;
  logic [1:0]  ack;
  logic [1:0]  grant;
  logic        busy;
  logic        fault;
  logic        cmd_start;
  logic        cmd_stop;
  logic        cmd_exerw;
  logic        cmd_rwb;
  logic [7:0]  tx_data;
  logic        status_busy;
  logic        status_byted;

  modport master (
    output req, req_sub, req_wdata, status_busy, status_byted,
    input  ack, grant, busy, fault, cmd_start, cmd_stop, cmd_exerw, cmd_rwb, tx_data
  );

  modport slave (
    input  req, req_sub, req_wdata, status_busy, status_byted,
    output ack, grant, busy, fault, cmd_start, cmd_stop, cmd_exerw, cmd_rwb, tx_data
  );
endinterface

// File: rtl/sccb_req_arbiter.sv
// Two-requester round-robin arbiter that sequences a 3-phase SCCB write
// (ID, sub-address, data) through a byte-level transceiver.
module sccb_req_arbiter #(
  parameter logic [6:0]  DEV_ID      = 7'h21,
  parameter int unsigned GAP_CYC     = 1000,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input logic               sys_clk,
  input logic               rst_n,
  sccb_req_arbiter_if.slave bus
);

  localparam int unsigned GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [7:0]    ID_BYTE  = {DEV_ID, 1'b0};

  typedef enum logic [2:0] {IDLE, START, ID, SUB, DATA, STOP, GAP, FAULT} state_t;

  state_t        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic [1:0]    ack_q, ack_d;
  logic          last_q, last_d;
  logic [7:0]    sub_q, sub_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    tx_q, tx_d;
  logic          start_q, start_d;
  logic          exerw_q, exerw_d;
  logic          stop_q, stop_d;
  logic          busy_q, busy_d;
  logic          fault_q, fault_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          win;

  // With both requests up the requester not served last wins; otherwise the lone one.
  assign win = (bus.req == 2'b11) ? ~last_q : bus.req[1];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ack_d   = 2'b00;
    last_d  = last_q;
    sub_d   = sub_q;
    wdata_d = wdata_q;
    tx_d    = tx_q;
    start_d = 1'b0;
    exerw_d = 1'b0;
    stop_d  = 1'b0;
    gap_d   = gap_q;
    tmo_d   = tmo_q;

    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d = START;
          grant_d = win ? 2'b10 : 2'b01;
          last_d  = win;
          sub_d   = win ? bus.req_sub[15:8] : bus.req_sub[7:0];
          wdata_d = win ? bus.req_wdata[15:8] : bus.req_wdata[7:0];
          start_d = 1'b1;
          tx_d    = ID_BYTE;
        end
      end
      START: state_d = ID;
      ID: begin
        if (bus.status_byted) begin
          exerw_d = 1'b1;
          tx_d    = sub_q;
          state_d = SUB;
        end else if (tmo_q == TMO_LAST) begin
          state_d = FAULT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      SUB: begin
        if (bus.status_byted) begin
          exerw_d = 1'b1;
          tx_d    = wdata_q;
          state_d = DATA;
        end else if (tmo_q == TMO_LAST) begin
          state_d = FAULT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      DATA: begin
        if (bus.status_byted) begin
          stop_d  = 1'b1;
          state_d = STOP;
        end else if (tmo_q == TMO_LAST) begin
          state_d = FAULT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      STOP: begin
        stop_d = 1'b1;
        if (!bus.status_busy) begin
          ack_d   = grant_q;
          stop_d  = 1'b0;
          grant_d = 2'b00;
          state_d = (GAP_CYC == 0) ? IDLE : GAP;
        end else if (bus.status_byted) begin
          tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
          stop_d  = 1'b0;
          state_d = FAULT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      FAULT: state_d = FAULT;
      default: state_d = IDLE;
    endcase

    // Both counters restart whenever a new state is entered.
    if (state_d != state_q) begin
      tmo_d = '0;
      gap_d = '0;
    end
    if (state_d == FAULT) begin
      grant_d = 2'b00;
    end
    busy_d  = (state_d != IDLE);
    fault_d = (state_d == FAULT);
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      ack_q   <= 2'b00;
      last_q  <= 1'b1;
      sub_q   <= 8'h00;
      wdata_q <= 8'h00;
      tx_q    <= 8'h00;
      start_q <= 1'b0;
      exerw_q <= 1'b0;
      stop_q  <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
      gap_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      last_q  <= last_d;
      sub_q   <= sub_d;
      wdata_q <= wdata_d;
      tx_q    <= tx_d;
      start_q <= start_d;
      exerw_q <= exerw_d;
      stop_q  <= stop_d;
      busy_q  <= busy_d;
      fault_q <= fault_d;
      gap_q   <= gap_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.grant     = grant_q;
  assign bus.busy      = busy_q;
  assign bus.fault     = fault_q;
  assign bus.cmd_start = start_q;
  assign bus.cmd_stop  = stop_q;
  assign bus.cmd_exerw = exerw_q;
  assign bus.cmd_rwb   = 1'b0;
  assign bus.tx_data   = tx_q;

endmodule

// File: tb/tb_sccb_req_arbiter.sv
// Directed scoreboard bench for sccb_req_arbiter with a cycle-stepped
// transceiver model; expected bytes, grants and acks are queued up front.
module tb_sccb_req_arbiter;

  localparam int BYTE_CYC = 4;

  logic clk;
  logic rst_n;

  sccb_req_arbiter_if bus_if();

  sccb_req_arbiter #(
    .DEV_ID      (7'h21),
    .GAP_CYC     (4),
    .TIMEOUT_CYC (64)
  ) dut (
    .sys_clk (clk),
    .rst_n   (rst_n),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_bytes[$];
  logic [1:0] exp_grant[$];
  logic [1:0] exp_ack[$];

  int   byte_timer = 0;
  int   stop_timer = 0;
  int   byte_no = 0;
  int   n_start = 0;
  int   n_exerw = 0;
  int   n_ack = 0;
  logic withhold = 1'b0;
  logic inject = 1'b0;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] req, input logic [15:0] sub, input logic [15:0] wdata);
    bus_if.req       = req;
    bus_if.req_sub   = sub;
    bus_if.req_wdata = wdata;
  endtask

  task automatic clearCounts();
    n_start = 0;
    n_exerw = 0;
    n_ack   = 0;
  endtask

  // One clock: sample DUT outputs just after the edge, then advance the transceiver model.
  task automatic step();
    @(posedge clk);
    #1;
    if (bus_if.cmd_start || bus_if.cmd_exerw) begin
      checkOutput("start_exerw_excl", 16'(bus_if.cmd_start & bus_if.cmd_exerw), 16'd0);
      if (bus_if.cmd_start) begin
        n_start++;
        byte_no = 1;
        if (exp_grant.size() == 0) checkOutput("grant_queue", 16'(exp_grant.size()), 16'd1);
        else checkOutput("grant", 16'(bus_if.grant), 16'(exp_grant.pop_front()));
      end else begin
        n_exerw++;
        byte_no++;
      end
      if (exp_bytes.size() == 0) checkOutput("byte_queue", 16'(exp_bytes.size()), 16'd1);
      else checkOutput("tx_byte", 16'(bus_if.tx_data), 16'(exp_bytes.pop_front()));
      byte_timer = BYTE_CYC;
      bus_if.status_busy = 1'b1;
    end
    if (bus_if.ack != 2'b00) begin
      n_ack++;
      if (exp_ack.size() == 0) checkOutput("ack_queue", 16'(exp_ack.size()), 16'd1);
      else checkOutput("ack", 16'(bus_if.ack), 16'(exp_ack.pop_front()));
    end
    bus_if.status_byted = inject;
    inject = 1'b0;
    if (byte_timer > 0) begin
      byte_timer--;
      if (byte_timer == 0 && !(withhold && byte_no == 2)) bus_if.status_byted = 1'b1;
    end
    if (bus_if.cmd_stop && stop_timer == 0 && bus_if.status_busy) begin
      stop_timer = 3;
    end else if (stop_timer > 0) begin
      stop_timer--;
      if (stop_timer == 0) bus_if.status_busy = 1'b0;
    end
  endtask

  task automatic runUntilAck(input int target, input int budget);
    int cyc = 0;
    while (n_ack < target && cyc < budget) begin
      step();
      cyc++;
    end
    if (n_ack < target) checkOutput("ack_timeout", 16'(n_ack), 16'(target));
  endtask

  task automatic runUntilExerw(input int target, input int budget);
    int cyc = 0;
    while (n_exerw < target && cyc < budget) begin
      step();
      cyc++;
    end
    if (n_exerw < target) checkOutput("exerw_timeout", 16'(n_exerw), 16'(target));
  endtask

  task automatic waitIdle(input int budget, output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (bus_if.busy && cycles < budget);
  endtask

  task automatic pushTxn(input logic [1:0] who, input logic [7:0] sub, input logic [7:0] wdata);
    exp_bytes.push_back(8'h42);
    exp_bytes.push_back(sub);
    exp_bytes.push_back(wdata);
    exp_grant.push_back(who);
  endtask

  initial begin
    int n;
    clk = 1'b0;
    rst_n = 1'b0;
    applyStimulus(2'b00, 16'h0000, 16'h0000);
    bus_if.status_busy  = 1'b0;
    bus_if.status_byted = 1'b0;
    repeat (3) step();

    $display("[TB] reset state");
    checkOutput("rst_busy", 16'(bus_if.busy), 16'd0);
    checkOutput("rst_grant", 16'(bus_if.grant), 16'd0);
    checkOutput("rst_ack", 16'(bus_if.ack), 16'd0);
    checkOutput("rst_fault", 16'(bus_if.fault), 16'd0);
    checkOutput("rst_tx", 16'(bus_if.tx_data), 16'd0);
    checkOutput("rst_cmds", 16'({bus_if.cmd_start, bus_if.cmd_stop, bus_if.cmd_exerw, bus_if.cmd_rwb}), 16'd0);
    rst_n = 1'b1;
    repeat (2) step();

    $display("[TB] contention: both requesters held for two transactions");
    clearCounts();
    pushTxn(2'b01, 8'h12, 8'h80);
    pushTxn(2'b10, 8'h34, 8'h56);
    exp_ack.push_back(2'b01);
    exp_ack.push_back(2'b10);
    applyStimulus(2'b11, 16'h3412, 16'h5680);
    runUntilAck(2, 400);
    applyStimulus(2'b00, 16'h3412, 16'h5680);
    waitIdle(40, n);
    checkOutput("rr_starts", 16'(n_start), 16'd2);
    checkOutput("rr_exerws", 16'(n_exerw), 16'd4);

    $display("[TB] single write, wdata changed after grant, byted injected in GAP");
    clearCounts();
    pushTxn(2'b01, 8'h12, 8'h80);
    exp_ack.push_back(2'b01);
    applyStimulus(2'b01, 16'h0012, 16'h0080);
    step();
    applyStimulus(2'b00, 16'h0012, 16'h0000);
    runUntilAck(1, 200);
    checkOutput("busy_at_ack", 16'(bus_if.busy), 16'd1);
    inject = 1'b1;
    waitIdle(40, n);
    checkOutput("gap_len", 16'(n), 16'd4);
    checkOutput("t1_starts", 16'(n_start), 16'd1);
    checkOutput("t1_exerws", 16'(n_exerw), 16'd2);
    checkOutput("t1_acks", 16'(n_ack), 16'd1);

    $display("[TB] byted injected in IDLE");
    inject = 1'b1;
    repeat (5) step();
    checkOutput("idle_busy", 16'(bus_if.busy), 16'd0);
    checkOutput("idle_cmds", 16'(n_start + n_exerw), 16'd3);
    checkOutput("tx_hold", 16'(bus_if.tx_data), 16'h80);

    $display("[TB] reset during DATA with request held");
    clearCounts();
    pushTxn(2'b01, 8'h5A, 8'hC3);
    pushTxn(2'b01, 8'h5A, 8'hC3);
    exp_ack.push_back(2'b01);
    applyStimulus(2'b01, 16'h005A, 16'h00C3);
    runUntilExerw(2, 100);
    step();
    rst_n = 1'b0;
    #1;
    byte_timer = 0;
    stop_timer = 0;
    bus_if.status_busy  = 1'b0;
    bus_if.status_byted = 1'b0;
    checkOutput("mid_rst_busy", 16'(bus_if.busy), 16'd0);
    checkOutput("mid_rst_grant", 16'(bus_if.grant), 16'd0);
    checkOutput("mid_rst_tx", 16'(bus_if.tx_data), 16'd0);
    checkOutput("mid_rst_cmds", 16'({bus_if.cmd_start, bus_if.cmd_stop, bus_if.cmd_exerw}), 16'd0);
    checkOutput("mid_rst_acks", 16'(n_ack), 16'd0);
    repeat (2) step();
    rst_n = 1'b1;
    runUntilAck(1, 200);
    applyStimulus(2'b00, 16'h005A, 16'h00C3);
    waitIdle(40, n);
    checkOutput("rst_restarts", 16'(n_start), 16'd2);

    $display("[TB] timeout: second byted withheld");
    clearCounts();
    withhold = 1'b1;
    exp_bytes.push_back(8'h42);
    exp_bytes.push_back(8'h77);
    exp_grant.push_back(2'b10);
    applyStimulus(2'b10, 16'h7700, 16'h9900);
    runUntilExerw(1, 100);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus_if.fault && n < 200);
    checkOutput("fault_latency", 16'(n), 16'd64);
    checkOutput("fault_grant", 16'(bus_if.grant), 16'd0);
    checkOutput("fault_busy", 16'(bus_if.busy), 16'd1);
    checkOutput("fault_cmds", 16'({bus_if.cmd_start, bus_if.cmd_stop, bus_if.cmd_exerw}), 16'd0);
    applyStimulus(2'b11, 16'h7777, 16'h9999);
    repeat (10) step();
    checkOutput("fault_sticky", 16'(bus_if.fault), 16'd1);
    checkOutput("fault_no_start", 16'(n_start), 16'd1);
    checkOutput("fault_no_ack", 16'(n_ack), 16'd0);
    checkOutput("left_bytes", 16'(exp_bytes.size()), 16'd0);
    checkOutput("left_acks", 16'(exp_ack.size() + exp_grant.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sccb_req_arbiter.md
SCCB_REQ_ARBITER -- requirements
Module: sccb_req_arbiter

Interface
REQ-001 Parameter DEV_ID, default 7'h21: 7-bit SCCB device ID sent in the ID phase with write bit 0.
REQ-002 Parameter GAP_CYC, default 1000: idle sys_clk cycles inserted after each completed transaction; 0 means no gap.
REQ-003 Parameter TIMEOUT_CYC, default 100000: maximum cycles allowed in any wait state before a fault.
REQ-004 sys_clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req  input  2  per-requester write request level; bit i is requester i.
REQ-007 req_sub  input  16  sub-addresses; [8i+7:8i] belongs to requester i.
REQ-008 req_wdata  input  16  write data; [8i+7:8i] belongs to requester i.
REQ-009 ack  output  2  one-cycle completion pulse to the granted requester.
REQ-010 grant  output  2  one-hot owner of the transaction in progress; 0 when idle.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 fault  output  1  high in FAULT; sticky until reset.
REQ-013 cmd_start, cmd_stop, cmd_exerw, cmd_rwb  output  1 each  transceiver commands; cmd_rwb is tied 0 (write only).
REQ-014 tx_data  output  8  byte presented to the transceiver.
REQ-015 status_busy, status_byted  input  1 each  transceiver status; status_byted is a one-cycle pulse after each byte and its ACK slot.

Function
REQ-016 All outputs SHALL be registered.
REQ-017 States SHALL be IDLE, START, ID, SUB, DATA, STOP, GAP, FAULT.
REQ-018 IDLE with any req bit high: arbitrate, latch the winner's sub/wdata, set grant, and go to START on the next edge.
REQ-019 Arbitration SHALL be round-robin: with both bits high, grant the requester not granted last; with one bit high, grant that one.
REQ-020 The last-grant pointer SHALL reset to 1, so requester 0 wins the first contention.
REQ-021 Latched sub/wdata SHALL be used for the whole transaction; input changes after the grant are ignored.
REQ-022 START: cmd_start high for exactly one cycle, tx_data={DEV_ID,1'b0}, then go to ID.
REQ-023 ID on status_byted: cmd_exerw high one cycle, tx_data=latched sub, go to SUB.
REQ-024 SUB on status_byted: cmd_exerw high one cycle, tx_data=latched wdata, go to DATA.
REQ-025 DATA on status_byted: go to STOP.
REQ-026 STOP: cmd_stop held high; when status_busy=0, pulse ack[grant] for one cycle, clear cmd_stop and grant, go to GAP.
REQ-027 tx_data SHALL hold its value between updates; cmd_exerw and cmd_start SHALL never be high in the same cycle.
REQ-028 GAP: count GAP_CYC cycles, then go to IDLE; with GAP_CYC=0, go straight from STOP to IDLE.
REQ-029 req is ignored outside IDLE; a req held high after its ack starts a new transaction.
REQ-030 Timeout counter: cleared on every state entry and on status_byted; counts in ID, SUB, DATA and STOP.
REQ-031 When the timeout counter reaches TIMEOUT_CYC-1, go to FAULT.
REQ-032 FAULT: all cmd_* low, no ack, grant cleared, fault=1, busy=1; exit only by reset.
REQ-033 A status_byted pulse arriving in IDLE, START, STOP or GAP SHALL be ignored.

Reset
REQ-034 rst_n low SHALL immediately force: IDLE; ack, grant, busy, fault, all cmd_* and tx_data to 0; all counters to 0; last-grant to 1.
REQ-035 Reset asserted mid-transaction SHALL abort without ack; the first transaction after release starts from START.

Verification
REQ-036 Test parameters: GAP_CYC=4, TIMEOUT_CYC=64, with a transceiver model. req=01, sub0=8'h12, wdata0=8'h80 -> cmd_start once; tx_data sequence 8'h42, 8'h12, 8'h80; exactly two cmd_exerw pulses; ack=01 once; busy low 4 cycles after ack.
REQ-037 req=11 held through two transactions -> grant sequence 01 then 10; acks 01 then 10.
REQ-038 req0 wdata changed from 8'h80 to 8'h00 one cycle after grant -> the third byte is still 8'h80.
REQ-039 Model withholds the second status_byted -> fault=1 in SUB after 64 cycles; no ack; req then ignored.
REQ-040 rst_n pulsed low during DATA -> outputs reset immediately; no ack; a held req restarts at START with tx_data=8'h42.
REQ-041 status_byted injected in IDLE and in GAP -> no state change and no cmd pulse.
